// File: rtl/alu_operand_stage_pkg.sv
// Shared op-code constants and issue-stage state type for alu_operand_stage and logic_unit.
package alu_operand_stage_pkg;

  localparam int unsigned ALU_OP_SEL_WIDTH = 3;

  localparam logic [ALU_OP_SEL_WIDTH-1:0] ALU_OP_AND  = 3'b111;
  localparam logic [ALU_OP_SEL_WIDTH-1:0] ALU_OP_OR   = 3'b110;
  localparam logic [ALU_OP_SEL_WIDTH-1:0] ALU_OP_XOR  = 3'b100;
  localparam logic [ALU_OP_SEL_WIDTH-1:0] ALU_OP_NOT1 = 3'b000;
  localparam logic [ALU_OP_SEL_WIDTH-1:0] ALU_OP_NOT2 = 3'b001;

  // ST_HEAD: only HEAD valid; ST_FULL: HEAD and SKID valid
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HEAD  = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  function automatic logic [1:0] state_occupancy(input stage_state_e s);
    case (s)
      ST_HEAD: return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/alu_operand_stage_legal_check.sv
// Combinational check: is the op code one that logic_unit implements.
module alu_op_legal_check
  import alu_operand_stage_pkg::*;
#(
  parameter int unsigned OP_SEL_WIDTH = ALU_OP_SEL_WIDTH
) (
  input  logic [OP_SEL_WIDTH-1:0] op_select,
  output logic                    legal
);

  always_comb begin
    legal = (op_select == OP_SEL_WIDTH'(ALU_OP_AND))  ||
            (op_select == OP_SEL_WIDTH'(ALU_OP_OR))   ||
            (op_select == OP_SEL_WIDTH'(ALU_OP_XOR))  ||
            (op_select == OP_SEL_WIDTH'(ALU_OP_NOT1)) ||
            (op_select == OP_SEL_WIDTH'(ALU_OP_NOT2));
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Registered issue stage feeding logic_unit: 2-entry skid buffer (HEAD/SKID) with registered
// in_ready, plus illegal-op flagging and a saturating illegal-op counter.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int unsigned OPD_LENGTH    = 8,
  parameter int unsigned OP_SEL_WIDTH  = 3,
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPD_LENGTH-1:0]    in_opd1,
  input  logic [OPD_LENGTH-1:0]    in_opd2,
  input  logic [OP_SEL_WIDTH-1:0]  in_op_select,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPD_LENGTH-1:0]    opd1,
  output logic [OPD_LENGTH-1:0]    opd2,
  output logic [OP_SEL_WIDTH-1:0]  alu_op_select,
  output logic                     out_illegal,
  output logic [1:0]               occupancy,
  output logic [ERR_CNT_WIDTH-1:0] illegal_count
);

  stage_state_e state_q, state_d;
  logic         in_ready_q, in_ready_d;

  logic [OPD_LENGTH-1:0]    head_opd1_q, head_opd2_q, skid_opd1_q, skid_opd2_q;
  logic [OP_SEL_WIDTH-1:0]  head_op_q, skid_op_q;
  logic [ERR_CNT_WIDTH-1:0] illegal_count_q;

  logic in_xfer;
  logic head_load_in, head_load_skid, skid_load;
  logic in_legal, head_legal;

  alu_op_legal_check #(.OP_SEL_WIDTH(OP_SEL_WIDTH)) u_in_check (
    .op_select (in_op_select),
    .legal     (in_legal)
  );

  alu_op_legal_check #(.OP_SEL_WIDTH(OP_SEL_WIDTH)) u_head_check (
    .op_select (head_op_q),
    .legal     (head_legal)
  );

  // flush discards the offered input, so it is not an accepted transfer
  assign in_xfer = in_valid & in_ready_q & ~flush;

  always_comb begin
    state_d        = state_q;
    in_ready_d     = in_ready_q;
    head_load_in   = 1'b0;
    head_load_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      state_d    = ST_EMPTY;
      in_ready_d = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            head_load_in = 1'b1;
            state_d      = ST_HEAD;
          end
        end
        ST_HEAD: begin
          if (in_xfer && out_ready) begin
            head_load_in = 1'b1;
          end else if (in_xfer) begin
            skid_load  = 1'b1;
            state_d    = ST_FULL;
            in_ready_d = 1'b0;
          end else if (out_ready) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            head_load_skid = 1'b1;
            state_d        = ST_HEAD;
            in_ready_d     = 1'b1;
          end
        end
        default: begin
          state_d    = ST_EMPTY;
          in_ready_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_EMPTY;
      in_ready_q      <= 1'b1;
      head_opd1_q     <= '0;
      head_opd2_q     <= '0;
      head_op_q       <= '0;
      skid_opd1_q     <= '0;
      skid_opd2_q     <= '0;
      skid_op_q       <= '0;
      illegal_count_q <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      if (head_load_in) begin
        head_opd1_q <= in_opd1;
        head_opd2_q <= in_opd2;
        head_op_q   <= in_op_select;
      end else if (head_load_skid) begin
        head_opd1_q <= skid_opd1_q;
        head_opd2_q <= skid_opd2_q;
        head_op_q   <= skid_op_q;
      end
      if (skid_load) begin
        skid_opd1_q <= in_opd1;
        skid_opd2_q <= in_opd2;
        skid_op_q   <= in_op_select;
      end
      if (in_xfer && !in_legal && (illegal_count_q != '1)) begin
        illegal_count_q <= illegal_count_q + ERR_CNT_WIDTH'(1);
      end
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = (state_q != ST_EMPTY);
  assign occupancy     = state_occupancy(state_q);
  assign opd1          = head_opd1_q;
  assign opd2          = head_opd2_q;
  assign alu_op_select = head_op_q;
  assign out_illegal   = out_valid & ~head_legal;
  assign illegal_count = illegal_count_q;

endmodule
